scan_chain_engine: RTL

SCAN_CHAIN_ENGINE -- requirements
Module: scan_chain_engine

---
 rtl/scan_chain_pkg.sv | 25 ++
 rtl/scan_chain_engine_if.sv | 27 ++
 rtl/scan_phase_gen.sv | 49 ++++
 rtl/scan_chain_engine.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/scan_chain_pkg.sv
// Shared types and helpers for the scan chain engine.
package scan_chain_pkg;

    localparam int unsigned IO_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        WAIT,
        CAPTURE,
        READ,
        DONE
    } scan_state_e;

    // Serial position of tile 'tile', io bit 'io' in a LOAD or READ shift.
    // The first bit shifted in travels furthest, so it lands on the last tile.
    function automatic int unsigned bit_index(int unsigned num_designs,
                                              int unsigned io_bits,
                                              int unsigned tile,
                                              int unsigned io);
        return io_bits * (num_designs - 1 - tile) + (io_bits - 1 - io);
    endfunction

endpackage

// File: rtl/scan_chain_engine_if.sv
// Host-side request/response bundle of the scan chain engine.
//
// Handshake: start is a one-cycle request and is only honoured while busy is
// low; a start seen while busy is high is dropped.  An accepted request holds
// busy high until the cycle after the outputs_valid pulse.  A request naming a
// tile that does not exist is answered with a one-cycle sel_error pulse.
interface scan_chain_engine_if import scan_chain_pkg::*; #(
    parameter int unsigned IO_BITS = IO_BITS_DEFAULT
);
    logic               start;
    logic [8:0]         active_select;
    logic [IO_BITS-1:0] inputs;
    logic [IO_BITS-1:0] outputs;
    logic               outputs_valid;
    logic               busy;
    logic               sel_error;

    modport master (
        output start, active_select, inputs,
        input  outputs, outputs_valid, busy, sel_error
    );

    modport slave (
        input  start, active_select, inputs,
        output outputs, outputs_valid, busy, sel_error
    );
endinterface

// File: rtl/scan_phase_gen.sv
// Two-cycle scan bit phase generator with bit counter.
module scan_phase_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             phase_o,
    output logic             phase_d_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o
);

    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Phase toggles every enabled cycle; the bit count advances after phase 1.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            phase_d = 1'b0;
            cnt_d   = '0;
        end else if (en_i) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Phase and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phase_o   = phase_q;
    assign phase_d_o = phase_d;
    assign cnt_o     = cnt_q;
    assign cnt_d_o   = cnt_d;

endmodule

// File: rtl/scan_chain_engine.sv
// Scan chain engine: loads one tile's inputs, latches, waits, captures and
// reads that tile's outputs back through a serial chain of NUM_DESIGNS tiles.
module scan_chain_engine import scan_chain_pkg::*; #(
    parameter int unsigned NUM_DESIGNS = 20,
    parameter int unsigned IO_BITS     = IO_BITS_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    scan_chain_engine_if.slave   host,
    output logic                 scan_clk_out,
    output logic                 scan_data_out,
    output logic                 scan_select,
    output logic                 scan_latch_en,
    input  logic                 scan_data_in,
    output scan_state_e          dbg_state
);

    localparam int unsigned CHAIN_LEN = NUM_DESIGNS * IO_BITS;
    localparam int unsigned CNT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned WAIT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYCLES - 1);

    scan_state_e        state_q, state_d;
    logic [8:0]         sel_q, sel_d;
    logic [IO_BITS-1:0] din_q, din_d;
    logic [IO_BITS-1:0] rd_q, rd_d;
    logic [IO_BITS-1:0] out_q;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_d;
    logic               scan_clk_q, sdo_q, ssel_q, slat_q;
    logic               valid_q, busy_q, err_q;
    logic               load_bit;
    logic               sel_ok;

    logic               pg_en, pg_clr;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    scan_phase_gen #(.CNT_W(CNT_W)) u_phase (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (pg_clr),
        .en_i      (pg_en),
        .phase_o   (phase_q),
        .phase_d_o (phase_d),
        .cnt_o     (cnt_q),
        .cnt_d_o   (cnt_d)
    );

    assign sel_ok = (32'(host.active_select) < NUM_DESIGNS);
    // Every state change restarts the bit phase at phase 0, bit 0.
    assign pg_clr = (state_d != state_q);

    // Next-state logic, request capture and READ bit collection.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        din_d   = din_q;
        rd_d    = rd_q;
        wait_d  = '0;
        err_d   = 1'b0;
        pg_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    if (sel_ok) begin
                        state_d = LOAD;
                        sel_d   = host.active_select;
                        din_d   = host.inputs;
                        rd_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                pg_en = 1'b1;
                if (phase_q && cnt_q == LAST_BIT) state_d = LATCH;
            end
            LATCH: begin
                pg_en = 1'b1;
                if (phase_q) state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == LAST_WAIT) state_d = CAPTURE;
            end
            CAPTURE: begin
                pg_en = 1'b1;
                if (phase_q) state_d = READ;
            end
            READ: begin
                pg_en = 1'b1;
                // scan_data_in is taken at the end of phase 1 of each bit.
                if (phase_q) begin
                    for (int unsigned i = 0; i < IO_BITS; i++) begin
                        if (cnt_q == CNT_W'(bit_index(NUM_DESIGNS, IO_BITS, 32'(sel_q), i))) begin
                            rd_d[i] = scan_data_in;
                        end
                    end
                    if (cnt_q == LAST_BIT) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial value for the bit about to be presented during LOAD.
    always_comb begin
        load_bit = 1'b0;
        for (int unsigned i = 0; i < IO_BITS; i++) begin
            if (cnt_d == CNT_W'(bit_index(NUM_DESIGNS, IO_BITS, 32'(sel_d), i))) begin
                load_bit = din_d[i];
            end
        end
    end

    // State, request and registered outputs; outputs follow the next state so
    // they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            din_q      <= '0;
            rd_q       <= '0;
            out_q      <= '0;
            wait_q     <= '0;
            scan_clk_q <= 1'b0;
            sdo_q      <= 1'b0;
            ssel_q     <= 1'b0;
            slat_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            din_q      <= din_d;
            rd_q       <= rd_d;
            wait_q     <= wait_d;
            scan_clk_q <= phase_d && (state_d == LOAD || state_d == CAPTURE || state_d == READ);
            sdo_q      <= (state_d == LOAD) && load_bit;
            ssel_q     <= (state_d == CAPTURE);
            slat_q     <= (state_d == LATCH);
            valid_q    <= (state_d == DONE);
            busy_q     <= (state_d != IDLE);
            err_q      <= err_d;
            if (state_d == DONE) out_q <= rd_d;
        end
    end

    assign host.outputs       = out_q;
    assign host.outputs_valid = valid_q;
    assign host.busy          = busy_q;
    assign host.sel_error     = err_q;
    assign scan_clk_out       = scan_clk_q;
    assign scan_data_out      = sdo_q;
    assign scan_select        = ssel_q;
    assign scan_latch_en      = slat_q;
    assign dbg_state          = state_q;

endmodule
